// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry type for the two-wide instruction fetch queue.
package fetch_queue_pkg;

    localparam int WIDTH    = 32;
    localparam int FQ_DEPTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode-facing signals of the fetch queue; master is the pipeline, slave is the queue.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             enq_valid_0;
    logic             enq_valid_1;
    logic [WIDTH-1:0] enq_pc_0;
    logic [WIDTH-1:0] enq_pc_1;
    logic [WIDTH-1:0] enq_instr_0;
    logic [WIDTH-1:0] enq_instr_1;
    logic             stall_F;
    logic [1:0]       deq_take;
    logic             out_valid_0;
    logic             out_valid_1;
    logic [WIDTH-1:0] out_pc_0;
    logic [WIDTH-1:0] out_pc_1;
    logic [WIDTH-1:0] out_instr_0;
    logic [WIDTH-1:0] out_instr_1;
    logic [CW-1:0]    count;

    modport master (
        output flush, enq_valid_0, enq_valid_1, enq_pc_0, enq_pc_1,
               enq_instr_0, enq_instr_1, deq_take,
        input  stall_F, out_valid_0, out_valid_1, out_pc_0, out_pc_1,
               out_instr_0, out_instr_1, count
    );

    modport slave (
        input  flush, enq_valid_0, enq_valid_1, enq_pc_0, enq_pc_1,
               enq_instr_0, enq_instr_1, deq_take,
        output stall_F, out_valid_0, out_valid_1, out_pc_0, out_pc_1,
               out_instr_0, out_instr_1, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Two-wide in-order fetch queue: circular buffer taking up to two entries in and
// presenting the two oldest to decode each cycle; flush discards everything.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input logic         clk,
    input logic         rst,
    fetch_queue_if.slave fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t       mem [DEPTH];
    logic [PW-1:0]   rd;
    logic [PW-1:0]   wr;
    logic [CW-1:0]   cnt;
    logic            stall;
    logic [1:0]      take;
    logic [1:0]      n_enq;
    logic [1:0]      n_deq;
    fq_entry_t       slot0;
    fq_entry_t       slot1;

    // Stall looks only at registered occupancy, so fetch never sees a comb path.
    assign stall = (cnt > CW'(DEPTH - 2));

    always_comb begin
        take = (fq.deq_take == 2'd3) ? 2'd2 : fq.deq_take;
        n_deq = (CW'(take) > cnt) ? cnt[1:0] : take;
        n_enq = 2'd0;
        if (!stall && !fq.flush && fq.enq_valid_0)
            n_enq = fq.enq_valid_1 ? 2'd2 : 2'd1;
        slot0 = '{pc: fq.enq_pc_0, instr: fq.enq_instr_0};
        slot1 = '{pc: fq.enq_pc_1, instr: fq.enq_instr_1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (fq.flush) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (n_enq != 2'd0)
                mem[wr] <= slot0;
            if (n_enq == 2'd2)
                mem[wr + PW'(1)] <= slot1;
            wr  <= wr + PW'(n_enq);
            rd  <= rd + PW'(n_deq);
            cnt <= cnt + CW'(n_enq) - CW'(n_deq);
        end
    end

    assign fq.stall_F     = stall;
    assign fq.count       = cnt;
    assign fq.out_valid_0 = (cnt >= CW'(1));
    assign fq.out_valid_1 = (cnt >= CW'(2));
    assign fq.out_pc_0    = mem[rd].pc;
    assign fq.out_instr_0 = mem[rd].instr;
    assign fq.out_pc_1    = mem[rd + PW'(1)].pc;
    assign fq.out_instr_1 = mem[rd + PW'(1)].instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH = 8): fill/stall, dequeue, flush, wrap, underflow, reset.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fetch_queue_if #(.DEPTH(8)) fq ();

    fetch_queue #(.DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic v1, input logic [31:0] p0,
                         input logic [31:0] p1, input logic [1:0] take, input logic fl);
        fq.enq_valid_0 = v0;
        fq.enq_valid_1 = v1;
        fq.enq_pc_0    = p0;
        fq.enq_pc_1    = p1;
        fq.enq_instr_0 = ~p0;
        fq.enq_instr_1 = ~p1;
        fq.deq_take    = take;
        fq.flush       = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic stall,
                             input logic [31:0] pc0, input logic [31:0] pc1);
        chk({tag, "_count"}, 32'(fq.count), 32'(cnt));
        chk({tag, "_stall"}, 32'(fq.stall_F), 32'(stall));
        chk({tag, "_v0"}, 32'(fq.out_valid_0), 32'(cnt >= 1));
        chk({tag, "_v1"}, 32'(fq.out_valid_1), 32'(cnt >= 2));
        if (cnt >= 1) begin
            chk({tag, "_pc0"}, fq.out_pc_0, pc0);
            chk({tag, "_in0"}, fq.out_instr_0, ~pc0);
        end
        if (cnt >= 2) begin
            chk({tag, "_pc1"}, fq.out_pc_1, pc1);
            chk({tag, "_in1"}, fq.out_instr_1, ~pc1);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_count"}, 32'(fq.count), 32'd0);
        chk({tag, "_stall"}, 32'(fq.stall_F), 32'd0);
        chk({tag, "_v0"}, 32'(fq.out_valid_0), 32'd0);
        chk({tag, "_v1"}, 32'(fq.out_valid_1), 32'd0);
        chk({tag, "_pc0"}, fq.out_pc_0, 32'd0);
        chk({tag, "_pc1"}, fq.out_pc_1, 32'd0);
        chk({tag, "_in0"}, fq.out_instr_0, 32'd0);
        chk({tag, "_in1"}, fq.out_instr_1, 32'd0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_zero("reset");

        // No same-cycle bypass into an empty queue
        drive(1'b1, 1'b1, 32'h0, 32'h4, 2'd0, 1'b0);
        #1;
        chk("nobypass_v0", 32'(fq.out_valid_0), 32'd0);
        tick();
        chk_state("enq1", 2, 1'b0, 32'h0, 32'h4);

        drive(1'b1, 1'b1, 32'h8, 32'hC, 2'd0, 1'b0);
        tick();
        chk_state("enq2", 4, 1'b0, 32'h0, 32'h4);
        drive(1'b1, 1'b1, 32'h10, 32'h14, 2'd0, 1'b0);
        tick();
        chk_state("enq3", 6, 1'b0, 32'h0, 32'h4);
        // Enqueue at count 6 is still accepted (stall low)
        drive(1'b1, 1'b1, 32'h18, 32'h1C, 2'd0, 1'b0);
        tick();
        chk_state("full", 8, 1'b1, 32'h0, 32'h4);
        // Enqueue into a full queue is ignored; entry 0 must not be overwritten
        drive(1'b1, 1'b1, 32'h20, 32'h24, 2'd0, 1'b0);
        tick();
        chk_state("full_hold", 8, 1'b1, 32'h0, 32'h4);

        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd1, 1'b0);
        tick();
        chk_state("deq1", 7, 1'b1, 32'h4, 32'h8);
        // Still stalled at count 7: enqueue dropped, dequeue of 2 proceeds
        drive(1'b1, 1'b1, 32'h30, 32'h34, 2'd2, 1'b0);
        tick();
        chk_state("deq2", 5, 1'b0, 32'hC, 32'h10);

        drive(1'b1, 1'b1, 32'h38, 32'h3C, 2'd2, 1'b1);
        tick();
        chk_state("flush", 0, 1'b0, 32'h0, 32'h0);
        idle();
        tick();
        chk_state("flush_after", 0, 1'b0, 32'h0, 32'h0);

        // Walk pointers to rd = wr = 7 with simultaneous enq/deq
        drive(1'b1, 1'b1, 32'h40, 32'h44, 2'd0, 1'b0);
        tick();
        chk_state("walk_a", 2, 1'b0, 32'h40, 32'h44);
        drive(1'b1, 1'b1, 32'h48, 32'h4C, 2'd2, 1'b0);
        tick();
        chk_state("walk_b", 2, 1'b0, 32'h48, 32'h4C);
        drive(1'b1, 1'b1, 32'h50, 32'h54, 2'd2, 1'b0);
        tick();
        chk_state("walk_c", 2, 1'b0, 32'h50, 32'h54);
        drive(1'b1, 1'b0, 32'h58, 32'h5C, 2'd2, 1'b0);
        tick();
        chk_state("single", 1, 1'b0, 32'h58, 32'h0);
        // Younger slot alone is ignored
        drive(1'b0, 1'b1, 32'h60, 32'h64, 2'd1, 1'b0);
        tick();
        chk_state("v1_only", 0, 1'b0, 32'h0, 32'h0);

        // Two-entry enqueue straddling the wrap (entries 7 and 0)
        drive(1'b1, 1'b1, 32'h100, 32'h104, 2'd0, 1'b0);
        tick();
        chk_state("wrap_enq", 2, 1'b0, 32'h100, 32'h104);
        drive(1'b1, 1'b1, 32'h108, 32'h10C, 2'd2, 1'b0);
        tick();
        chk_state("wrap_deq", 2, 1'b0, 32'h108, 32'h10C);

        drive(1'b1, 1'b1, 32'h110, 32'h114, 2'd0, 1'b0);
        tick();
        chk_state("pre_take3", 4, 1'b0, 32'h108, 32'h10C);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd3, 1'b0);
        tick();
        chk_state("take3", 2, 1'b0, 32'h110, 32'h114);
        drive(1'b1, 1'b0, 32'h118, 32'h11C, 2'd2, 1'b0);
        tick();
        chk_state("to_one", 1, 1'b0, 32'h118, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        tick();
        chk_state("underflow", 0, 1'b0, 32'h0, 32'h0);
        tick();
        chk_state("underflow2", 0, 1'b0, 32'h0, 32'h0);

        drive(1'b1, 1'b1, 32'h200, 32'h204, 2'd0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h208, 32'h20C, 2'd0, 1'b0);
        tick();
        chk_state("pre_rst", 4, 1'b0, 32'h200, 32'h204);
        drive(1'b1, 1'b1, 32'h210, 32'h214, 2'd2, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk_zero("mid_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
